// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: scan control and shadow inputs from the config datapath, pin-level outputs.
// Pure wiring with no latency; there is no handshake and the consumer cannot apply backpressure.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    lz_en;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [DW-1:0]           digit_o;
    logic                    frame_o;

    modport master (
        output en, load, value_i, dp_i, lz_en,
        input  seg_o, dp_o, an_o, digit_o, frame_o
    );

    modport slave (
        input  en, load, value_i, dp_i, lz_en,
        output seg_o, dp_o, an_o, digit_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: shadowed digits, leading-zero blanking, anode guard, frame pulse.
// seg/dp/an are registered one clock behind digit_o; the display sink has no backpressure.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 500,
    parameter bit HEX_MODE       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [DW-1:0] dig_t;

    localparam cnt_t CNT_LAST = cnt_t'(REFRESH_DIV - 1);
    localparam cnt_t GUARD_C  = cnt_t'(GUARD);
    localparam dig_t DIG_LAST = dig_t'(NUM_DIGITS - 1);

    cnt_t                    cnt_q, cnt_d;
    dig_t                    digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic                    frame_q, frame_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0]              digs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_up;
    logic                    wrap;
    logic                    blank;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (!HEX_MODE && c > 4'h9) begin
            g = 7'h40;
        end
        return g;
    endfunction

    // zero_up[k]: every shadow digit from k up to the most significant one is zero
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign digs[k]    = val_q[4*k +: 4];
        assign zero_up[k] = ~|val_q[4*NUM_DIGITS-1:4*k];
    end

    assign wrap  = (cnt_q == CNT_LAST);
    assign blank = bus.lz_en && (digit_q != '0) && zero_up[digit_q];

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        frame_d = 1'b0;
        val_d   = val_q;
        dpm_d   = dpm_q;
        seg_d   = '0;
        dp_d    = 1'b0;
        an_d    = '0;

        if (bus.load) begin
            val_d = bus.value_i;
            dpm_d = bus.dp_i;
        end

        if (bus.en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
                frame_d = (digit_q == DIG_LAST);
            end
            if (!blank) begin
                seg_d = glyph(digs[digit_q]);
                dp_d  = dpm_q[digit_q];
                // Anodes stay dark at the head of each slot so the previous digit cannot ghost
                if (cnt_q >= GUARD_C) begin
                    an_d = NUM_DIGITS'(1) << digit_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
            val_q   <= '0;
            dpm_q   <= '0;
            frame_q <= 1'b0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            val_q   <= val_d;
            dpm_q   <= dpm_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg_o   = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign bus.dp_o    = dp_q ^ SEG_ACTIVE_LOW;
    assign bus.an_o    = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    assign bus.digit_o = digit_q;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 4-clock slots, 1-clock guard, active-low pins.
// Two instances differ only in HEX_MODE; every lit cycle is scored against hand-computed glyphs.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus1 ();

    assign bus1.en      = bus0.en;
    assign bus1.load    = bus0.load;
    assign bus1.value_i = bus0.value_i;
    assign bus1.dp_i    = bus0.dp_i;
    assign bus1.lz_en   = bus0.lz_en;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        u_hex (.clk(clk), .rst_n(rst_n), .bus(bus0));

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(1'b0),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        u_dash (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [6:0] seg;
        logic [6:0] seg_nh;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [6:0] s, input logic [6:0] sn, input logic d,
                            input logic [3:0] an, input int n);
        exp_t e;
        e.seg = s; e.seg_nh = sn; e.dp = d; e.an = an;
        repeat (n) exp_q.push_back(e);
    endtask

    // One full 16-clock frame. Slot expectations: segs {s3,s2,s1,s0} (HEX_MODE=1 and 0),
    // pin-level dp per slot, and which slots light. An optional load lands on the wrap edge.
    task automatic run_frame(input logic [27:0] s, input logic [27:0] sn, input logic [3:0] dpv,
                             input logic [3:0] lit, input logic ld, input logic [15:0] nv,
                             input logic [3:0] ndp, input logic nlz, input bit drop);
        logic [3:0] an_exp;
        for (int i = 0; i < 4; i++) begin
            if (lit[i]) begin
                an_exp = ~(4'b0001 << i);
                push_exp(s[7*i +: 7], sn[7*i +: 7], dpv[i], an_exp, 3);
            end
        end
        for (int e = 1; e <= 16; e++) begin
            if (ld && e == 16) begin
                bus0.load    = 1'b1;
                bus0.value_i = nv;
                bus0.dp_i    = ndp;
            end
            tick();
            bus0.load = 1'b0;
            if (drop && e == 10) begin
                bus0.en = 1'b0;
                repeat (10) begin
                    tick();
                    @(negedge clk);
                    check("en_low_hold", {bus0.seg_o, bus0.dp_o, bus0.an_o, bus0.digit_o, bus0.frame_o},
                          {7'h7F, 1'b1, 4'hF, 2'd2, 1'b0});
                end
                bus0.en = 1'b1;
            end
        end
        bus0.lz_en = nlz;
        @(negedge clk);
        check("frame_pulse", {bus0.frame_o, bus0.digit_o}, {1'b1, 2'd0});
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.frame_o) frames_seen++;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus0.an_o !== 4'hF) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_lit actual seg=%0h an=%0h required=none at %0t",
                         bus0.seg_o, bus0.an_o, $time);
            end else begin
                e = exp_q.pop_front();
                check("lit_hex", {bus0.seg_o, bus0.dp_o, bus0.an_o}, {e.seg, e.dp, e.an});
                check("lit_dash", {bus1.seg_o, bus1.an_o}, {e.seg_nh, e.an});
            end
        end
    end

    initial begin
        bus0.en = 1'b0; bus0.load = 1'b0; bus0.value_i = '0; bus0.dp_i = '0; bus0.lz_en = 1'b0;
        repeat (2) tick();
        check("in_reset", {bus0.seg_o, bus0.dp_o, bus0.an_o, bus0.digit_o, bus0.frame_o},
              {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0});
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            @(negedge clk);
            check("idle_after_reset", {bus0.seg_o, bus0.dp_o, bus0.an_o, bus0.digit_o, bus0.frame_o},
                  {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0});
        end

        bus0.value_i = 16'h1234; bus0.dp_i = 4'b0010; bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        bus0.en = 1'b1;

        // 1234, dp on digit 1
        run_frame({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101, 4'b1111,
                  1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        run_frame({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101, 4'b1111,
                  1'b1, 16'h0050, 4'h0, 1'b1, 1'b0);
        // 0050 with suppression: slots 3 and 2 dark
        run_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 4'b0011,
                  1'b1, 16'h0000, 4'h0, 1'b1, 1'b0);
        // 0000: digit 0 is never suppressed
        run_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b0001,
                  1'b1, 16'h000B, 4'h0, 1'b1, 1'b0);
        // 000B: 'b' in hex mode, dash otherwise
        run_frame({7'h7F, 7'h7F, 7'h7F, 7'h03}, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1111, 4'b0001,
                  1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
        bus0.value_i = 16'h9999;
        run_frame({7'h7F, 7'h7F, 7'h7F, 7'h03}, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1111, 4'b0001,
                  1'b1, 16'h9999, 4'h0, 1'b1, 1'b0);
        // 9999 loaded on the wrap edge; en dropped for 10 clocks inside slot 2
        run_frame({7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111, 4'b1111,
                  1'b0, 16'h0, 4'h0, 1'b1, 1'b1);

        // Partial frame, then asynchronous reset while slot 1 is lit
        push_exp(7'h10, 7'h10, 1'b1, 4'b1110, 3);
        push_exp(7'h10, 7'h10, 1'b1, 4'b1101, 1);
        repeat (6) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus0.seg_o, bus0.dp_o, bus0.an_o, bus0.digit_o, bus0.frame_o},
              {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0});
        repeat (2) tick();
        rst_n = 1'b1;
        // Shadow cleared by reset, suppression still on
        run_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b0001,
                  1'b0, 16'h0, 4'h0, 1'b1, 1'b0);

        tick();
        check("queue_drained", exp_q.size(), 0);
        check("frame_count", frames_seen, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit BCD/hex-to-7-segment decoder.
- Drives a time-multiplexed display of NUM_DIGITS digits from one packed nibble bus: shadow-register capture, per-digit decimal point, optional leading-zero suppression, hex/dash mode, anti-ghosting guard interval and frame pulse.
- Sits between the SPI/UART configuration datapath and the board's common-anode/cathode display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal 1..8.
- REFRESH_DIV, 50000, clocks per digit slot; legal >= 2.
- GUARD, 500, clocks at the start of each slot with all anodes off; legal 0..REFRESH_DIV-1.
- HEX_MODE, 1, 1: codes 10..15 show A b C d E F; 0: codes 10..15 show a dash (g only).
- SEG_ACTIVE_LOW, 1, seg_o/dp_o polarity.
- AN_ACTIVE_LOW, 1, an_o polarity.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- load  in  1  capture strobe for value_i/dp_i
- value_i  in  4*NUM_DIGITS  digit k = value_i[4k+3:4k]; digit 0 is least significant
- dp_i  in  NUM_DIGITS  per-digit decimal point, 1 = lit
- lz_en  in  1  leading-zero suppression enable
- seg_o  out  7  segments {g,f,e,d,c,b,a}, a = bit 0
- dp_o  out  1  decimal point
- an_o  out  NUM_DIGITS  one-hot digit select
- digit_o  out  DW = max(1, $clog2(NUM_DIGITS))  current slot index
- frame_o  out  1  one-cycle pulse on wrap to digit 0

Behaviour:
- Reset (async, rst_n low): prescaler=0, digit_o=0, shadow value=0, shadow dp=0, frame_o=0. seg_o/dp_o all unlit; an_o all inactive (polarity applied).
- Shadow: load high at a clock edge copies value_i/dp_i into the shadow registers. Display uses the shadow only, so a mid-frame value_i change without load has no effect.
- Prescaler: when en=1, counts 0..REFRESH_DIV-1 and wraps. At count REFRESH_DIV-1, digit_o advances, wrapping NUM_DIGITS-1 -> 0. frame_o=1 in the cycle following that wrap edge only.
- en=0: prescaler and digit_o hold; from the next edge all outputs are unlit/inactive; frame_o=0. Re-enable resumes from the held count.
- Glyphs (positive logic, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 dash=40.
- Leading-zero suppression: digit i (i >= 1) is blanked when lz_en=1 and shadow digits NUM_DIGITS-1..i are all zero. Digit 0 is never blanked.
- Blanked digit: seg_o unlit, dp_o unlit, an_o all inactive for its whole slot.
- Output registers: seg_o, dp_o, an_o are registered from the prescaler count, digit_o and shadow as they stand before each edge. They lag digit_o by exactly one clock.
  - an_o is all-inactive during the cycles the pre-edge count is < GUARD.
  - Otherwise an_o has only bit digit_o active.
- Polarity: SEG_ACTIVE_LOW=1 inverts the glyph and dp. AN_ACTIVE_LOW=1 inverts an_o.
- Simultaneous load and digit advance: both occur. The new shadow is used from the next output-register update.
- lz_en is sampled live, not shadowed.
- Reset asserted mid-slot: immediate return to reset values. The first slot after release starts at digit 0, count 0.
- NUM_DIGITS=1: digit_o stays 0; frame_o pulses every REFRESH_DIV cycles.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, both polarities active-low unless stated):
- Reset and release with en=0 -> seg_o=7F, dp_o=1, an_o=4'b1111, digit_o=0, frame_o=0, held indefinitely.
- load value_i=16'h1234, dp_i=4'b0010, lz_en=0, en=1:
  - slot 0: seg_o=19, an_o=4'b1110 for 3 of 4 cycles, 4'b1111 for 1 guard cycle.
  - slot 1: seg_o=30, dp_o=0.
  - slot 2: seg_o=24.
  - slot 3: seg_o=79.
  - frame_o pulses every 16 cycles.
- lz_en=1, load 16'h0050:
  - slots 3 and 2: an_o=4'b1111 throughout.
  - slot 1: seg_o=12.
  - slot 0: seg_o=40.
  - load 16'h0000: only slot 0 lights, seg_o=40.
- load 16'h000B:
  - HEX_MODE=1: slot 0 seg_o=03.
  - HEX_MODE=0: slot 0 seg_o=3F.
- Change value_i to 16'h9999 without load mid-frame -> display unchanged. Pulse load coincident with the slot-3 to slot-0 advance -> next lit slot 0 shows seg_o=10.
- Drop en for 10 cycles mid-slot 2 -> outputs blank, digit_o holds 2, no frame_o. Assert rst_n=0 mid-slot -> outputs go to reset values without waiting for a clock edge.
